multi_digit_counter_display: RTL and testbench

MULTI_DIGIT_COUNTER_DISPLAY -- requirements
Module: multi_digit_counter_display

---
 rtl/multi_digit_counter_display_pkg.sv | 36 +++
 rtl/multi_digit_counter_display_btn_debounce_edge.sv | 56 +++++
 rtl/multi_digit_counter_display.sv | 152 +++++++++++++++
 tb/tb_multi_digit_counter_display.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_display_pkg.sv
// Shared 7-segment constants, BCD digit type and the digit decoder used by
// the multi-digit counter display.
package multi_digit_counter_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-low segment patterns, bit6 = a down to bit0 = g.
    localparam logic [6:0] SEG_DIGIT_0 = 7'b0000001;
    localparam logic [6:0] SEG_DIGIT_1 = 7'b1001111;
    localparam logic [6:0] SEG_DIGIT_2 = 7'b0010010;
    localparam logic [6:0] SEG_DIGIT_3 = 7'b0000110;
    localparam logic [6:0] SEG_DIGIT_4 = 7'b1001100;
    localparam logic [6:0] SEG_DIGIT_5 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT_6 = 7'b0100000;
    localparam logic [6:0] SEG_DIGIT_7 = 7'b0001111;
    localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
    localparam logic [6:0] SEG_DIGIT_9 = 7'b0000100;
    localparam logic [6:0] SEG_BLANK   = 7'b1111111;

    function automatic logic [6:0] seg_decode(input bcd_digit_t digit);
        case (digit)
            4'd0:    return SEG_DIGIT_0;
            4'd1:    return SEG_DIGIT_1;
            4'd2:    return SEG_DIGIT_2;
            4'd3:    return SEG_DIGIT_3;
            4'd4:    return SEG_DIGIT_4;
            4'd5:    return SEG_DIGIT_5;
            4'd6:    return SEG_DIGIT_6;
            4'd7:    return SEG_DIGIT_7;
            4'd8:    return SEG_DIGIT_8;
            4'd9:    return SEG_DIGIT_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/multi_digit_counter_display_btn_debounce_edge.sv
// Button front end: 2-flop synchroniser, counting debouncer and a one-cycle
// press pulse on each accepted 0->1 transition.
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the run.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/multi_digit_counter_display.sv
// Debounced up/down BCD counter with multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module multi_digit_counter_display
    import multi_digit_counter_display_pkg::*;
#(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_CYCLES     = 1000,
    parameter int WRAP            = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button_plus,
    input  logic                  button_minus,
    output logic [6:0]            segment,
    output logic [DIGITS-1:0]     anode,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  limit
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic plus_pulse;
    logic minus_pulse;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_plus (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_plus),
        .press   (plus_pulse)
    );

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_minus (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (button_minus),
        .press   (minus_pulse)
    );

    bcd_digit_t        digit_q [DIGITS];
    bcd_digit_t        digit_d [DIGITS];
    logic              limit_q, limit_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [6:0]        segment_q, segment_d;
    logic [DIGITS-1:0] anode_q, anode_d;

    logic step_up, step_dn, all_nines, all_zero, ripple;

    // Decimal ripple increment/decrement; at the extremes the ripple itself
    // produces the wrapped value, so saturation only has to suppress it.
    always_comb begin
        step_up   = plus_pulse & ~minus_pulse;
        step_dn   = minus_pulse & ~plus_pulse;
        all_nines = 1'b1;
        all_zero  = 1'b1;
        ripple    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_d[i] = digit_q[i];
            if (digit_q[i] != 4'd9) all_nines = 1'b0;
            if (digit_q[i] != 4'd0) all_zero  = 1'b0;
        end
        limit_d = (step_up & all_nines) | (step_dn & all_zero);
        if (step_up && (WRAP != 0 || !all_nines)) begin
            ripple = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    if (digit_q[i] >= 4'd9) begin
                        digit_d[i] = 4'd0;
                    end else begin
                        digit_d[i] = digit_q[i] + 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
        end else if (step_dn && (WRAP != 0 || !all_zero)) begin
            ripple = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (ripple) begin
                    if (digit_q[i] == 4'd0) begin
                        digit_d[i] = 4'd9;
                    end else begin
                        digit_d[i] = digit_q[i] - 4'd1;
                        ripple     = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q >= SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q >= IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic above_zero, blank_sel;

    // Walk down from the top digit; the selected digit is blank while every
    // digit from the top down to it is zero. Digit 0 is never blanked.
    always_comb begin
        above_zero = 1'b1;
        blank_sel  = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            above_zero = above_zero & (digit_q[i] == 4'd0);
            if (scan_idx_q == IDX_W'(i) && above_zero) blank_sel = 1'b1;
        end
        segment_d = blank_sel ? SEG_BLANK : seg_decode(digit_q[scan_idx_q]);
        anode_d   = ~(DIGITS'(1) << scan_idx_q);
    end
`else
    always_comb begin
        segment_d = seg_decode(digit_q[scan_idx_q]);
        anode_d   = ~(DIGITS'(1) << scan_idx_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'd0;
            limit_q    <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            segment_q  <= SEG_BLANK;
            anode_q    <= '1;
        end else begin
            for (int i = 0; i < DIGITS; i++) digit_q[i] <= digit_d[i];
            limit_q    <= limit_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            segment_q  <= segment_d;
            anode_q    <= anode_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_pack
            assign count_bcd[4*gi +: 4] = digit_q[gi];
        end
    endgenerate

    assign segment = segment_q;
    assign anode   = anode_q;
    assign limit   = limit_q;

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Directed bench: one wrapping and one saturating counter driven by shared
// buttons, checked with immediate assertions against hand-computed values.
module tb_multi_digit_counter_display;

    localparam int D    = 4;
    localparam int S    = 8;
    localparam int HOLD = 2 * D + 6;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] EXP_LZ = 7'b1111111;
`else
    localparam logic [6:0] EXP_LZ = 7'b0000001;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp  = 1'b0;
    logic bm  = 1'b0;

    logic [6:0]  seg_w, seg_s;
    logic [3:0]  an_w, an_s;
    logic [15:0] cnt_w, cnt_s;
    logic        lim_w, lim_s;

    int total = 0;
    int bad   = 0;
    int lim_w_cnt = 0;
    int lim_s_cnt = 0;

    always #5 clk = ~clk;

    multi_digit_counter_display #(
        .DIGITS(4), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .WRAP(1)
    ) dut_wrap (
        .clk(clk), .rst(rst), .button_plus(bp), .button_minus(bm),
        .segment(seg_w), .anode(an_w), .count_bcd(cnt_w), .limit(lim_w)
    );

    multi_digit_counter_display #(
        .DIGITS(4), .DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S), .WRAP(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .button_plus(bp), .button_minus(bm),
        .segment(seg_s), .anode(an_s), .count_bcd(cnt_s), .limit(lim_s)
    );

    // Number of cycles each limit output was seen high.
    always @(negedge clk) begin
        if (lim_w) lim_w_cnt++;
        if (lim_s) lim_s_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic p, input logic m);
        bp = p;
        bm = m;
        repeat (HOLD) @(negedge clk);
        bp = 1'b0;
        bm = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_anode(input string tag, input logic [3:0] target);
        int n = 0;
        while (an_w !== target && n < 8 * S) begin
            @(negedge clk);
            n++;
        end
        check(tag, {28'd0, an_w}, {28'd0, target});
    endtask

    int lw0, ls0;
    logic [3:0] an_seq [4];
    logic [6:0] seg_3  [4];

    initial begin
        an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_3  = '{7'b0000110, EXP_LZ, EXP_LZ, EXP_LZ};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_count",  cnt_w, 16'h0000);
        check("rst_limit",  lim_w, 1'b0);
        check("rst_seg",    seg_w, 7'b1111111);
        check("rst_anode",  an_w,  4'b1111);
        check("rst_seg_s",  seg_s, 7'b1111111);
        check("rst_anode_s", an_s, 4'b1111);

        // First cycle after release: digit 0 selected and decoded
        rst = 1'b0;
        @(negedge clk);
        check("first_anode", an_w,  4'b1110);
        check("first_seg",   seg_w, 7'b0000001);

        // Press one cycle too short to be accepted
        lw0 = lim_w_cnt;
        bp = 1'b1;
        repeat (D - 1) @(negedge clk);
        bp = 1'b0;
        repeat (3 * D) @(negedge clk);
        check("short_count", cnt_w, 16'h0000);
        check("short_limit", lim_w_cnt - lw0, 0);

        // 5 up, 2 down -> 0003
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        check("five_up", cnt_w, 16'h0005);
        for (int i = 0; i < 2; i++) press(1'b0, 1'b1);
        check("two_down", cnt_w, 16'h0003);

        // Scan sequence, each digit held for S cycles
        wait_anode("scan_sync_hi", 4'b0111);
        wait_anode("scan_sync_lo", 4'b1110);
        check("scan_seg0", seg_w, seg_3[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (S) @(negedge clk);
            check($sformatf("scan_anode%0d", k), an_w, an_seq[k]);
            check($sformatf("scan_seg%0d", k), seg_w, seg_3[k]);
        end

        // Decrement at 0: wrap to 9999 versus saturate at 0000
        do_reset();
        lw0 = lim_w_cnt;
        ls0 = lim_s_cnt;
        press(1'b0, 1'b1);
        check("wrap_dn_count", cnt_w, 16'h9999);
        check("wrap_dn_limit", lim_w_cnt - lw0, 1);
        check("sat_dn_count",  cnt_s, 16'h0000);
        check("sat_dn_limit",  lim_s_cnt - ls0, 1);

        // Increment at 9999 wraps to 0000
        lw0 = lim_w_cnt;
        press(1'b1, 1'b0);
        check("wrap_up_count", cnt_w, 16'h0000);
        check("wrap_up_limit", lim_w_cnt - lw0, 1);

        // Preload 0099 then carry into the hundreds
        do_reset();
        for (int i = 0; i < 99; i++) press(1'b1, 1'b0);
        check("preload_99", cnt_w, 16'h0099);
        lw0 = lim_w_cnt;
        press(1'b1, 1'b0);
        check("carry_100",       cnt_w, 16'h0100);
        check("carry_100_sat",   cnt_s, 16'h0100);
        check("carry_100_limit", lim_w_cnt - lw0, 0);

        // Simultaneous presses cancel
        lw0 = lim_w_cnt;
        ls0 = lim_s_cnt;
        press(1'b1, 1'b1);
        check("both_count",   cnt_w, 16'h0100);
        check("both_count_s", cnt_s, 16'h0100);
        check("both_limit",   lim_w_cnt - lw0, 0);
        check("both_limit_s", lim_s_cnt - ls0, 0);

        // 0042: display contents, then reset mid-scan
        do_reset();
        for (int i = 0; i < 42; i++) press(1'b1, 1'b0);
        check("preload_42", cnt_w, 16'h0042);
        wait_anode("d3_sel", 4'b0111);
        check("d3_seg", seg_w, EXP_LZ);
        wait_anode("d0_sel", 4'b1110);
        check("d0_seg", seg_w, 7'b0010010);
        wait_anode("d1_sel", 4'b1101);
        check("d1_seg", seg_w, 7'b1001100);
        wait_anode("d2_sel", 4'b1011);
        check("d2_seg", seg_w, EXP_LZ);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_seg",   seg_w, 7'b1111111);
        check("midrst_anode", an_w,  4'b1111);
        check("midrst_count", cnt_w, 16'h0000);
        check("midrst_limit", lim_w, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
